// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: writeback, debug and register-file signals around the write-port arbiter
interface regfile_port_arbiter_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;
  logic [XLEN-1:0] rf_rdata;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rf_raddr;
  logic            dbg_rd_sel;
  logic            stall;
  logic            clear_done;
  modport slave (
    input  wb_we, wb_rd, wb_data, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
    output dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata, rf_raddr, dbg_rd_sel, stall, clear_done
  );
  modport master (
    output wb_we, wb_rd, wb_data, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
    input  dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata, rf_raddr, dbg_rd_sel, stall, clear_done
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: post-reset clear, then shares the register-file write port between writeback and debug
module regfile_port_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic clk,
  input logic rst_n,
  regfile_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {CLEAR, IDLE, ISSUE, ACK} state_t;
  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ack;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            clr;
  logic            iss;
  logic            dbg_wr;
  always_comb begin
    clr    = state == CLEAR;
    iss    = state == ISSUE && !bus.wb_we;
    dbg_wr = iss && bus.dbg_we;
  end
  // writeback owns the port whenever it is active; debug only fills idle ISSUE cycles
  assign bus.rf_we      = clr || (bus.wb_we ? bus.wb_rd != '0 : dbg_wr && bus.dbg_addr != '0);
  assign bus.rf_waddr   = clr ? cnt : dbg_wr ? bus.dbg_addr : bus.wb_rd;
  assign bus.rf_wdata   = clr ? '0 : dbg_wr ? bus.dbg_wdata : bus.wb_data;
  assign bus.rf_raddr   = bus.dbg_addr;
  assign bus.dbg_rd_sel = iss && !bus.dbg_we;
  assign bus.stall      = state != IDLE;
  assign bus.dbg_ack    = ack;
  assign bus.dbg_rdata  = rdata;
  assign bus.clear_done = done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      ack   <= 1'b0;
      rdata <= '0;
      done  <= 1'b0;
    end else begin
      ack <= iss;
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREG - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        IDLE: if (bus.dbg_req) state <= ISSUE;
        ISSUE: if (!bus.wb_we) begin
          state <= ACK;
          if (!bus.dbg_we) rdata <= bus.rf_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Controller for the 32×32 integer register file. It owns the file's single write port and shares it between the pipeline writeback stage and a debug/host access port. After reset it sequences a zero-clear of every register and holds the pipeline stalled until the clear finishes. It sits between the WB stage, the debug module and the register file; the register file's A1 read port is muxed onto the debug address while a debug read is in progress.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers
- AW, 5, register address width (log2 NREG)

- clk  in  1  core clock; register file writes commit on its falling edge
- rst  in  1  asynchronous, active-low reset
- wb_we_i  in  1  writeback write enable
- wb_rd_i  in  AW  writeback destination
- wb_data_i  in  XLEN  writeback data
- dbg_req_i  in  1  debug request, held with addr/data/we until ack
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  AW  debug register index
- dbg_wdata_i  in  XLEN  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  XLEN  read result, registered, valid from ack onward
- rf_rdata_i  in  XLEN  register file RD1
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  AW  register file write address
- rf_wdata_o  out  XLEN  register file write data
- rf_raddr_o  out  AW  debug read address for A1 mux
- dbg_rd_sel_o  out  1  selects rf_raddr_o onto A1
- stall_o  out  1  freezes the pipeline front end
- clear_done_o  out  1  high once the post-reset clear has completed

## Operation
- FSM states: CLEAR, IDLE, ISSUE, ACK. Clear counter is AW bits wide.
- Reset values:
  - state = CLEAR, counter = 0.
  - dbg_ack_o = 0, dbg_rdata_o = 0, clear_done_o = 0.
  - stall_o = 1.
- CLEAR:
  - Drive rf_we_o = 1, rf_waddr_o = counter, rf_wdata_o = 0, stall_o = 1.
  - The counter increments each cycle.
  - After the cycle with counter = NREG-1, go to IDLE and set clear_done_o = 1; it stays high until the next reset.
  - wb_we_i is ignored during CLEAR.
- Writeback path (IDLE/ISSUE/ACK):
  - rf_we_o = wb_we_i && wb_rd_i != 0; address and data pass through combinationally.
  - Writeback always has priority and is never delayed.
- IDLE:
  - If dbg_req_i = 1, go to ISSUE.
  - A request raised during CLEAR stays pending and is taken in the first IDLE cycle.
- ISSUE:
  - stall_o = 1.
  - If wb_we_i = 1: stay in ISSUE; the writeback uses the port.
  - Else, write request: rf_we_o = (dbg_addr_i != 0), rf_waddr_o = dbg_addr_i, rf_wdata_o = dbg_wdata_i.
  - Else, read request: dbg_rd_sel_o = 1, rf_raddr_o = dbg_addr_i, and dbg_rdata_o captures rf_rdata_i at the rising edge.
  - After the debug operation, go to ACK.
- ACK:
  - dbg_ack_o = 1, stall_o = 1; go to IDLE.
  - In IDLE, stall_o = 0. A dbg_req_i still high in IDLE is treated as a new transaction, so requesters drop req the cycle after ack.
- x0 handling:
  - Writes to x0 from either source never assert rf_we_o.
  - A debug write to x0 still completes and is acked.
  - A debug read of x0 returns whatever the file supplies (0 after the clear).
- Reset mid-operation: any state returns to CLEAR with counter 0. A pending debug op is dropped without ack; the requester reissues.

## Timing
- Clear takes exactly NREG cycles after rst deasserts. clear_done_o and stall_o = 0 are seen in cycle NREG+1 (IDLE).
- Debug latency, request seen in IDLE in cycle N with no writeback conflict:
  - Op performed in cycle N+1.
  - dbg_ack_o high in cycle N+2.
  - Each cycle of wb_we_i = 1 during ISSUE adds one cycle.
- stall_o is high from the cycle after the request is seen through the ack cycle inclusive.
- dbg_rdata_o holds its value until the next debug read completes.
- A debug read never shares a cycle with a writeback write, so no same-cycle read/write race occurs.

## Test plan
- Reset, then release: rf_we_o = 1 for 32 cycles, addresses 0..31 with data 0. clear_done_o rises in cycle 33, and stall_o falls in the same cycle.
- Debug write x5 = 0xDEADBEEF in IDLE with no writeback: rf_we_o/rf_waddr_o = 5 with that data one cycle after the request, ack the cycle after, stall_o high for exactly 2 cycles.
- Debug read x5 while wb_we_i = 1 (rd = 7) for 3 consecutive cycles: the 3 writebacks pass unchanged, the read is issued in the 4th ISSUE cycle, and dbg_rdata_o = 0xDEADBEEF at ack.
- Writeback rd = 0 and debug write to x0: rf_we_o stays 0 and dbg_ack_o still pulses once.
- dbg_req_i asserted during CLEAR (counter = 10): no service until CLEAR ends, and the op completes 2 cycles after the first IDLE cycle.
- rst asserted in ISSUE: no ack ever issued for that op, and the counter restarts the clear from address 0.
